// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the bubble instruction, and register-field positions in an instruction word.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch channel: request/ready handshake for the address,
// rvalid strobe for the returned word.
interface if_fetch_stage_if;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_hazard_detect_unit.sv
// Load-use hazard compare between the IF/ID instruction and the load in ID/EX.
// Purely combinational so ID/EX bubble logic can share the same instance.
module hazard_detect_unit (
  input  logic       if_id_valid,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  output logic       hazard
);

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = if_id_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps at most one
// request outstanding, buffers one response while decode is stalled.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    reset,
  if_fetch_stage_if.master        imem,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  input  logic                    id_ex_mem_read,
  input  logic [4:0]              id_ex_rd,
  output logic [63:0]             F_PC_out,
  output logic [31:0]             F_Instruction,
  output logic                    F_valid,
  output logic                    stall_out
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  pc_seq;
  logic [63:0]  redirect_target;
  logic [31:0]  skid_data_q;
  logic         skid_load;
  logic         new_valid;
  logic [31:0]  new_instr;
  logic         hazard;

  hazard_detect_unit u_hazard (
    .if_id_valid    (F_valid),
    .if_id_rs1      (F_Instruction[RS1_MSB:RS1_LSB]),
    .if_id_rs2      (F_Instruction[RS2_MSB:RS2_LSB]),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .hazard         (hazard)
  );

  // A redirect flushes IF/ID anyway, so holding it would only delay the new path.
  assign stall_out       = hazard && !redirect_valid;
  assign pc_seq          = pc_q + 64'd4;
  assign redirect_target = redirect_pc & ~64'h3;

  assign imem.imem_req  = (state_q == FETCH) && !reset;
  assign imem.imem_addr = pc_q;

  // The skid buffer is valid exactly while in HOLD; the state doubles as its valid bit.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    skid_load = 1'b0;
    new_valid = 1'b0;
    new_instr = skid_data_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = imem.imem_ready ? DROP : FETCH;
        end else if (imem.imem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = imem.imem_rvalid ? FETCH : DROP;
        end else if (imem.imem_rvalid) begin
          if (stall_out) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            new_valid = 1'b1;
            new_instr = imem.imem_rdata;
            pc_d      = pc_seq;
            state_d   = FETCH;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = FETCH;
        end else if (!stall_out) begin
          new_valid = 1'b1;
          pc_d      = pc_seq;
          state_d   = FETCH;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = FETCH;
        end else if (imem.imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: skid data has no reset; it is only read in HOLD, after being loaded.
  always_ff @(posedge clk) begin
    if (skid_load) skid_data_q <= imem.imem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC_out      <= 64'h0;
      F_Instruction <= NOP_INSTR;
      F_valid       <= 1'b0;
    end else if (redirect_valid) begin
      F_Instruction <= NOP_INSTR;
      F_valid       <= 1'b0;
    end else if (!stall_out) begin
      if (new_valid) begin
        F_PC_out      <= pc_q;
        F_Instruction <= new_instr;
        F_valid       <= 1'b1;
      end else begin
        F_Instruction <= NOP_INSTR;
        F_valid       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed per-cycle vector table, hand-written reset
// sequence, zero-wait throughput, then randomized traffic against a stream model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic [63:0] F_PC_out;
  logic [31:0] F_Instruction;
  logic        F_valid;
  logic        stall_out;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .F_PC_out       (F_PC_out),
    .F_Instruction  (F_Instruction),
    .F_valid        (F_valid),
    .stall_out      (stall_out)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [63:0] redir_pc;
    logic        mem_read;
    logic [4:0]  rd;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_fv;
    logic [63:0] e_fpc;
    logic [31:0] e_fi;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ready, input logic rvalid, input logic [31:0] rdata,
                         input logic redir, input logic [63:0] redir_pc,
                         input logic mem_read, input logic [4:0] rd,
                         input logic e_req, input logic [63:0] e_addr,
                         input logic e_fv, input logic [63:0] e_fpc,
                         input logic [31:0] e_fi, input logic e_stall);
    vec_t v;
    v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
    v.redir = redir; v.redir_pc = redir_pc;
    v.mem_read = mem_read; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv;
    v.e_fpc = e_fpc; v.e_fi = e_fi; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  // Memory image used by the randomized phase: any address maps to a fixed word.
  function automatic logic [31:0] instr_at(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h13;
  endfunction

  // Stream model: decode must see PCs in program order from the last redirect target.
  logic [63:0] exp_pc;
  bit          pending;
  int          pend_wait;
  logic [63:0] pend_addr;
  int          consumed;
  int          idle;

  task automatic drive_idle();
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    id_ex_mem_read = 1'b0;
    id_ex_rd       = 5'd0;
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    pending  = 0;
    exp_pc   = 64'h0;
    consumed = 0;
    idle     = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit chaos);
    logic        redir;
    logic [63:0] tgt;
    bit          fire;
    logic        exp_stall;
    for (int i = 0; i < n; i++) begin
      redir = chaos && ($urandom_range(0, 99) < 3);
      tgt   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt[63:8] = '1;
      redirect_valid = redir;
      redirect_pc    = tgt;
      id_ex_mem_read = chaos && ($urandom_range(0, 9) < 4);
      id_ex_rd       = ($urandom_range(0, 1) == 1) ? F_Instruction[19:15]
                                                   : 5'($urandom_range(0, 31));
      imem_bus.imem_ready = chaos ? ($urandom_range(0, 9) < 6) : 1'b1;
      fire = 0;
      if (pending && pend_wait == 0) fire = 1;
      else if (pending) pend_wait--;
      imem_bus.imem_rvalid = fire;
      imem_bus.imem_rdata  = fire ? instr_at(pend_addr) : $urandom;
      #1;
      exp_stall = F_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  (id_ex_rd == F_Instruction[19:15] || id_ex_rd == F_Instruction[24:20]) &&
                  !redir;
      check("rand_stall_out", stall_out, exp_stall);
      if (fire) pending = 0;
      if (imem_bus.imem_req) check("rand_addr_align", imem_bus.imem_addr[1:0], 2'b00);
      if (imem_bus.imem_req && imem_bus.imem_ready) begin
        check("rand_one_outstanding", pending, 0);
        pending   = 1;
        pend_addr = imem_bus.imem_addr;
        pend_wait = chaos ? $urandom_range(0, 3) : 0;
      end
      if (redir) begin
        exp_pc = tgt & ~64'h3;
        idle   = 0;
      end else if (F_valid && !stall_out) begin
        check("rand_F_PC_out", F_PC_out, exp_pc);
        check("rand_F_Instruction", F_Instruction, instr_at(exp_pc));
        exp_pc = exp_pc + 64'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        check("rand_progress_timeout", idle, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive_idle();

    //       rdy rv  rdata         rd redir_pc        mr rd  req addr          fv fpc           fi            st
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h0,         0, 64'h0,        NOP,          0);
    add_vec(1, 1, 32'h00000093, 0, 64'h0,          0, 0,  0, 64'h0,         0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h4,         1, 64'h0,        32'h00000093, 0);
    add_vec(1, 1, 32'h00100113, 0, 64'h0,          0, 0,  0, 64'h4,         0, 64'h0,        NOP,          0);
    add_vec(0, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h8,         1, 64'h4,        32'h00100113, 0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h8,         0, 64'h0,        NOP,          0);
    add_vec(0, 1, 32'h00528333, 0, 64'h0,          0, 0,  0, 64'h8,         0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          1, 5,  1, 64'hC,         1, 64'h8,        32'h00528333, 1);
    add_vec(0, 1, 32'h00A00193, 0, 64'h0,          1, 5,  0, 64'hC,         1, 64'h8,        32'h00528333, 1);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  0, 64'hC,         1, 64'h8,        32'h00528333, 0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h10,        1, 64'hC,        32'h00A00193, 0);
    add_vec(0, 0, 32'h0,        1, 64'h103,        0, 0,  0, 64'h10,        0, 64'h0,        NOP,          0);
    add_vec(0, 1, 32'hDEADBEEF, 0, 64'h0,          0, 0,  0, 64'h100,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h100,       0, 64'h0,        NOP,          0);
    add_vec(0, 1, 32'h00200213, 0, 64'h0,          0, 0,  0, 64'h100,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h104,       1, 64'h100,      32'h00200213, 0);
    add_vec(0, 1, 32'h11111111, 1, 64'h200,        0, 0,  0, 64'h104,       0, 64'h0,        NOP,          0);
    add_vec(0, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h200,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h200,       0, 64'h0,        NOP,          0);
    add_vec(0, 1, 32'h00528333, 0, 64'h0,          0, 0,  0, 64'h200,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        1, 64'h300,        1, 5,  1, 64'h204,       1, 64'h200,      32'h00528333, 0);
    add_vec(0, 1, 32'h22222222, 0, 64'h0,          1, 5,  0, 64'h300,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'h300,       0, 64'h0,        NOP,          0);
    add_vec(0, 1, 32'h00000333, 0, 64'h0,          1, 0,  0, 64'h300,       0, 64'h0,        NOP,          0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          1, 0,  1, 64'h304,       1, 64'h300,      32'h00000333, 0);
    add_vec(0, 0, 32'h0,        1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 64'h304, 0, 64'h0,      NOP,          0);
    add_vec(0, 1, 32'h33333333, 0, 64'h0,          0, 0,  0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, NOP,      0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          0, 0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, NOP,      0);
    add_vec(0, 1, 32'h00000013, 0, 64'h0,          0, 0,  0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, NOP,      0);
    add_vec(1, 0, 32'h0,        0, 64'h0,          1, 0,  1, 64'h0,         1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00000013, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_imem_req", imem_bus.imem_req, 1'b0);
    check("reset_imem_addr", imem_bus.imem_addr, 64'h0);
    check("reset_F_valid", F_valid, 1'b0);
    check("reset_F_PC_out", F_PC_out, 64'h0);
    check("reset_F_Instruction", F_Instruction, NOP);
    check("reset_stall_out", stall_out, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      imem_bus.imem_ready  = vecs[i].ready;
      imem_bus.imem_rvalid = vecs[i].rvalid;
      imem_bus.imem_rdata  = vecs[i].rdata;
      redirect_valid       = vecs[i].redir;
      redirect_pc          = vecs[i].redir_pc;
      id_ex_mem_read       = vecs[i].mem_read;
      id_ex_rd             = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_imem_req", i), imem_bus.imem_req, vecs[i].e_req);
      check($sformatf("vec%0d_imem_addr", i), imem_bus.imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_F_valid", i), F_valid, vecs[i].e_fv);
      check($sformatf("vec%0d_F_Instruction", i), F_Instruction, vecs[i].e_fi);
      if (vecs[i].e_fv) check($sformatf("vec%0d_F_PC_out", i), F_PC_out, vecs[i].e_fpc);
      check($sformatf("vec%0d_stall_out", i), stall_out, vecs[i].e_stall);
      @(negedge clk);
    end

    // Asynchronous reset while a request is outstanding (state WAIT here).
    drive_idle();
    id_ex_mem_read = 1'b1;
    id_ex_rd       = 5'd0;
    reset          = 1'b1;
    #1;
    check("midreset_imem_req", imem_bus.imem_req, 1'b0);
    check("midreset_imem_addr", imem_bus.imem_addr, 64'h0);
    check("midreset_F_valid", F_valid, 1'b0);
    check("midreset_F_PC_out", F_PC_out, 64'h0);
    check("midreset_F_Instruction", F_Instruction, NOP);
    check("midreset_stall_out", stall_out, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    imem_bus.imem_ready = 1'b1;
    #1;
    check("restart_imem_req", imem_bus.imem_req, 1'b1);
    check("restart_imem_addr", imem_bus.imem_addr, 64'h0);
    @(negedge clk);
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h00000093;
    #1;
    check("restart_wait_req", imem_bus.imem_req, 1'b0);
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    #1;
    check("restart_F_valid", F_valid, 1'b1);
    check("restart_F_PC_out", F_PC_out, 64'h0);
    check("restart_F_Instruction", F_Instruction, 32'h00000093);
    check("restart_rd0_no_stall", stall_out, 1'b0);

    // Zero-wait memory, no hazards: one instruction every two cycles.
    do_reset();
    run_cycles(200, 1'b0);
    check("zero_wait_throughput", consumed, 99);

    do_reset();
    run_cycles(3000, 1'b1);
    check("random_made_progress", consumed > 300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
